// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults, array type and write-port selection for the register file
// Purpose : default widths, the default register array type, and the port-B-over-A
//           write selection used by the array, the read ports and the debug mirror.
// Ports   : none (package)
package rf_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef logic [DATA_W_DEF-1:0] regs_t [2**ADDR_W_DEF];

  typedef enum logic [1:0] {
    SEL_ARR = 2'd0,
    SEL_A   = 2'd1,
    SEL_B   = 2'd2
  } sel_t;

  // Port B (memory write-back) is the younger producer, so it wins a collision.
  function automatic sel_t rf_sel(input logic a_hit, input logic b_hit);
    if (b_hit) return SEL_B;
    if (a_hit) return SEL_A;
    return SEL_ARR;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port with write-first bypass and zero-reg mask
// Purpose : selects array data or same-cycle write data for one address and registers it,
//           together with the already-updated busy bit of that address.
// Ports   : i_clk, i_reset        clock, synchronous active-high reset
//           i_addr                read address
//           i_arr_data            array content at i_addr
//           i_busy_nxt            next-state busy bit at i_addr
//           i_wa_*/i_wb_*         write ports (enables already zero-reg qualified)
//           o_data, o_busy        registered read data and busy flag
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_arr_data,
  input  logic              i_busy_nxt,
  input  logic              i_wa_en,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [DATA_W-1:0] i_wa_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy
);

  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data;
  logic              r_busy;
  logic              w_busy;
  logic              w_zero;

  assign w_zero = (ZERO_REG != 0) && (i_addr == '0);

  always_comb begin
    w_data = i_arr_data;
    case (rf_sel(i_wa_en && (i_wa_addr == i_addr), i_wb_en && (i_wb_addr == i_addr)))
      SEL_A:   w_data = i_wa_data;
      SEL_B:   w_data = i_wb_data;
      default: w_data = i_arr_data;
    endcase
    // Hardwired zero register masks even a bypassed value.
    if (w_zero) w_data = '0;
  end

  assign w_busy = i_busy_nxt && !w_zero;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      r_data <= w_data;
      r_busy <= w_busy;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - register file with two write ports, bypass and busy scoreboard
// Purpose : decode-stage register file: NUM_RD registered read ports, write ports A/B
//           (B wins collisions), write-first bypass, per-register busy scoreboard and a
//           registered mirror of register DBG_REG.
// Ports   : i_clk, i_reset                 clock, synchronous active-high reset
//           i_rd_addr / o_rd_data          packed read addresses / registered read data
//           o_rd_busy                      registered next-state busy of each read address
//           i_wa_en/i_wa_addr/i_wa_data    write port A (ALU write-back)
//           i_wb_en/i_wb_addr/i_wb_data    write port B (memory write-back)
//           i_rsv_en/i_rsv_addr            destination reservation at issue
//           o_dbg_q                        registered copy of register DBG_REG
module reg_file_scoreboard
  import rf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int DBG_REG  = 7
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_wa_en,
  input  logic [ADDR_W-1:0]        i_wa_addr,
  input  logic [DATA_W-1:0]        i_wa_data,
  input  logic                     i_wb_en,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [DATA_W-1:0]        i_wb_data,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic [DATA_W-1:0]        o_dbg_q
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] DBG_ADDR = ADDR_W'(DBG_REG);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [DATA_W-1:0] r_dbg_q;
  logic [DATA_W-1:0] w_dbg_d;
  logic              w_wa_ok;
  logic              w_wb_ok;
  logic              w_rsv_ok;

  // Accesses to a hardwired zero register are dropped at the source, so neither the
  // array nor the scoreboard nor any bypass path ever sees them.
  assign w_wa_ok  = i_wa_en  && !((ZERO_REG != 0) && (i_wa_addr  == '0));
  assign w_wb_ok  = i_wb_en  && !((ZERO_REG != 0) && (i_wb_addr  == '0));
  assign w_rsv_ok = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == '0));

  // Clear on write first, then set on reserve: a same-cycle reservation belongs to a
  // newer producer and must leave the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < DEPTH; r++) begin
      if ((w_wa_ok && (i_wa_addr == ADDR_W'(r))) || (w_wb_ok && (i_wb_addr == ADDR_W'(r))))
        w_busy_nxt[r] = 1'b0;
      if (w_rsv_ok && (i_rsv_addr == ADDR_W'(r)))
        w_busy_nxt[r] = 1'b1;
    end
  end

  always_comb begin
    w_dbg_d = r_regs[DBG_ADDR];
    case (rf_sel(w_wa_ok && (i_wa_addr == DBG_ADDR), w_wb_ok && (i_wb_addr == DBG_ADDR)))
      SEL_A:   w_dbg_d = i_wa_data;
      SEL_B:   w_dbg_d = i_wb_data;
      default: w_dbg_d = r_regs[DBG_ADDR];
    endcase
    if ((ZERO_REG != 0) && (DBG_ADDR == '0)) w_dbg_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < DEPTH; r++) r_regs[r] <= '0;
      r_busy  <= '0;
      r_dbg_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        case (rf_sel(w_wa_ok && (i_wa_addr == ADDR_W'(r)), w_wb_ok && (i_wb_addr == ADDR_W'(r))))
          SEL_A:   r_regs[r] <= i_wa_data;
          SEL_B:   r_regs[r] <= i_wb_data;
          default: ;
        endcase
      end
      r_busy  <= w_busy_nxt;
      r_dbg_q <= w_dbg_d;
    end
  end

  assign o_dbg_q = r_dbg_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = i_rd_addr[g*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_addr     (w_addr),
      .i_arr_data (r_regs[w_addr]),
      .i_busy_nxt (w_busy_nxt[w_addr]),
      .i_wa_en    (w_wa_ok),
      .i_wa_addr  (i_wa_addr),
      .i_wa_data  (i_wa_data),
      .i_wb_en    (w_wb_ok),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data),
      .o_data     (o_rd_data[g*DATA_W +: DATA_W]),
      .o_busy     (o_rd_busy[g])
    );
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb/tb_reg_file_scoreboard.sv - self-checking bench for reg_file_scoreboard (two configurations)
module tb_reg_file_scoreboard;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rd_addr;
  logic        wa_en, wb_en, rsv_en;
  logic [2:0]  wa_addr, wb_addr, rsv_addr;
  logic [31:0] wa_data, wb_data;

  logic [31:0]  rd_data0;
  logic [1:0]   rd_busy0;
  logic [15:0]  dbg0;
  logic [127:0] rd_data1;
  logic [3:0]   rd_busy1;
  logic [31:0]  dbg1;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain arrays updated in program order (A, then B, then reserve).
  regs_t       m0_reg;
  logic [31:0] m1_reg [8];
  logic [7:0]  m0_busy, m1_busy;
  logic [15:0] e0_data [2];
  logic        e0_busy [2];
  logic [31:0] e1_data [4];
  logic        e1_busy [4];
  logic [15:0] e0_dbg;
  logic [31:0] e1_dbg;

  always #5 clk = ~clk;

  reg_file_scoreboard #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .DBG_REG(7)
  ) dut0 (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr[5:0]),
    .o_rd_data(rd_data0), .o_rd_busy(rd_busy0),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data[15:0]),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data[15:0]),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_dbg_q(dbg0)
  );

  reg_file_scoreboard #(
    .DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_REG(0), .DBG_REG(7)
  ) dut1 (
    .i_clk(clk), .i_reset(reset), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data1), .o_rd_busy(rd_busy1),
    .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_dbg_q(dbg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic [2:0] a;
    if (reset) begin
      for (int r = 0; r < 8; r++) begin
        m0_reg[r] = '0;
        m1_reg[r] = '0;
      end
      m0_busy = '0;
      m1_busy = '0;
    end else begin
      if (wa_en) begin
        if (wa_addr != 3'd0) begin
          m0_reg[wa_addr]  = wa_data[15:0];
          m0_busy[wa_addr] = 1'b0;
        end
        m1_reg[wa_addr]  = wa_data;
        m1_busy[wa_addr] = 1'b0;
      end
      if (wb_en) begin
        if (wb_addr != 3'd0) begin
          m0_reg[wb_addr]  = wb_data[15:0];
          m0_busy[wb_addr] = 1'b0;
        end
        m1_reg[wb_addr]  = wb_data;
        m1_busy[wb_addr] = 1'b0;
      end
      if (rsv_en) begin
        if (rsv_addr != 3'd0) m0_busy[rsv_addr] = 1'b1;
        m1_busy[rsv_addr] = 1'b1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      a = rd_addr[i*3 +: 3];
      e0_data[i] = m0_reg[a];
      e0_busy[i] = m0_busy[a];
    end
    for (int i = 0; i < 4; i++) begin
      a = rd_addr[i*3 +: 3];
      e1_data[i] = m1_reg[a];
      e1_busy[i] = m1_busy[a];
    end
    e0_dbg = m0_reg[7];
    e1_dbg = m1_reg[7];
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d0_rd_data%0d", i), 32'(rd_data0[i*16 +: 16]), 32'(e0_data[i]));
      chk($sformatf("d0_rd_busy%0d", i), 32'(rd_busy0[i]), 32'(e0_busy[i]));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d1_rd_data%0d", i), rd_data1[i*32 +: 32], e1_data[i]);
      chk($sformatf("d1_rd_busy%0d", i), 32'(rd_busy1[i]), 32'(e1_busy[i]));
    end
    chk("d0_dbg_q", 32'(dbg0), 32'(e0_dbg));
    chk("d1_dbg_q", dbg1, e1_dbg);
  endtask

  // Inputs are applied just after a falling edge; the following rising edge consumes them
  // and the next falling edge checks the registered outputs.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare_model();
    #1;
  endtask

  task automatic idle();
    reset  = 1'b0;
    wa_en  = 1'b0; wa_addr  = '0; wa_data = '0;
    wb_en  = 1'b0; wb_addr  = '0; wb_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic all_ports(input logic [2:0] a);
    rd_addr = {a, a, a, a};
  endtask

  initial begin
    idle();
    rd_addr = '0;
    reset   = 1'b1;
    tick();

    // Reset: preload, then reset with writes pending.
    for (int r = 1; r < 8; r++) begin
      idle();
      wa_en = 1'b1; wa_addr = 3'(r); wa_data = 32'h1111_1111 * r;
      rsv_en = 1'b1; rsv_addr = 3'(8 - r);
      all_ports(3'(r));
      tick();
    end
    idle();
    reset = 1'b1;
    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 32'hCAFE_F00D;
    rsv_en = 1'b1; rsv_addr = 3'd7;
    all_ports(3'd7);
    tick();
    chk("rst_rd_data0", rd_data0, 32'h0);
    chk("rst_rd_busy0", 32'(rd_busy0), 32'h0);
    chk("rst_dbg0", 32'(dbg0), 32'h0);
    chk("rst_rd_data1", rd_data1[31:0], 32'h0);
    chk("rst_rd_busy1", 32'(rd_busy1), 32'h0);
    chk("rst_dbg1", dbg1, 32'h0);
    idle();
    for (int a = 0; a < 8; a++) begin
      all_ports(3'(a));
      tick();
      chk("rst_read_d0", rd_data0, 32'h0);
      chk("rst_read_d1", rd_data1[127:96], 32'h0);
    end

    // Write then read.
    idle(); rd_addr = '0;
    wa_en = 1'b1; wa_addr = 3'd3; wa_data = 32'h0000_BEEF;
    tick();
    idle(); rd_addr = 12'd3;
    tick();
    chk("wr_rd_data0", 32'(rd_data0[15:0]), 32'h0000_BEEF);
    chk("wr_rd_busy0", 32'(rd_busy0[0]), 32'h0);

    // Bypass with A/B collision.
    idle(); rd_addr = {9'd0, 3'd5} << 3;
    wa_en = 1'b1; wa_addr = 3'd5; wa_data = 32'h0000_1111;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 32'h0000_2222;
    tick();
    chk("byp_d0_port1", 32'(rd_data0[31:16]), 32'h0000_2222);
    chk("byp_d1_port1", rd_data1[63:32], 32'h0000_2222);
    idle();
    tick();
    chk("coll_array_r5", 32'(rd_data0[31:16]), 32'h0000_2222);

    // Zero register.
    idle(); rd_addr = '0;
    wa_en = 1'b1; wa_addr = 3'd0; wa_data = 32'h0000_FFFF;
    rsv_en = 1'b1; rsv_addr = 3'd0;
    tick();
    chk("zero_d0_data", 32'(rd_data0[15:0]), 32'h0);
    chk("zero_d0_busy", 32'(rd_busy0[0]), 32'h0);
    chk("zero_d1_data", rd_data1[31:0], 32'h0000_FFFF);
    chk("zero_d1_busy", 32'(rd_busy1[0]), 32'h1);

    // Scoreboard.
    idle(); rd_addr = 12'd2;
    rsv_en = 1'b1; rsv_addr = 3'd2;
    tick();
    chk("sb_rsv_busy0", 32'(rd_busy0[0]), 32'h1);
    chk("sb_rsv_busy1", 32'(rd_busy1[0]), 32'h1);
    idle();
    tick();
    chk("sb_hold_busy", 32'(rd_busy0[0]), 32'h1);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 32'h0000_00AA;
    tick();
    chk("sb_clr_busy", 32'(rd_busy0[0]), 32'h0);
    chk("sb_clr_data", 32'(rd_data0[15:0]), 32'h0000_00AA);
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd2;
    wa_en = 1'b1; wa_addr = 3'd2; wa_data = 32'h0000_1234;
    tick();
    chk("sb_rsvwr_busy", 32'(rd_busy0[0]), 32'h1);
    chk("sb_rsvwr_data", 32'(rd_data0[15:0]), 32'h0000_1234);

    // Debug mirror and wide configuration.
    idle(); all_ports(3'd7);
    wa_en = 1'b1; wa_addr = 3'd7; wa_data = 32'hDEAD_BEEF;
    tick();
    chk("dbg_d1", dbg1, 32'hDEAD_BEEF);
    chk("dbg_d0", 32'(dbg0), 32'h0000_BEEF);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dbg_port%0d", i), rd_data1[i*32 +: 32], 32'hDEAD_BEEF);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      wa_en    = 1'($urandom_range(0, 1));
      wb_en    = 1'($urandom_range(0, 1));
      rsv_en   = 1'($urandom_range(0, 1));
      wa_addr  = 3'($urandom_range(0, 7));
      wb_addr  = ($urandom_range(0, 3) == 0) ? wa_addr : 3'($urandom_range(0, 7));
      rsv_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 3'($urandom_range(0, 7));
      wa_data  = $urandom;
      wb_data  = $urandom;
      rd_addr  = 12'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
